// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the register-bank/execute side and the
// HI/LO multiply/divide unit.
//   start, op, opA, opB      : operation request (master -> unit)
//   mt_hi, mt_lo, wdata      : direct HI/LO writes (master -> unit)
//   busy, done, div_by_zero  : status (unit -> master)
//   hi, lo                   : HI/LO register contents (unit -> master)
// All data vectors are [0:WIDTH-1]; index 0 is the MSB, as in the register bank.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [0:WIDTH-1]   opA;
  logic [0:WIDTH-1]   opB;
  logic               mt_hi;
  logic               mt_lo;
  logic [0:WIDTH-1]   wdata;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [0:WIDTH-1]   hi;
  logic [0:WIDTH-1]   lo;

  modport master (
    output start, op, opA, opB, mt_hi, mt_lo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, mt_hi, mt_lo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the HI/LO result pair.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. A radix-2 core runs WIDTH
// iterations on operand magnitudes, then a FIX cycle applies sign correction,
// writes HI/LO and pulses done. MTHI/MTLO writes are accepted only when idle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : muldiv_unit_if slave (request, mt writes, status, HI/LO)
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  // Magnitude of a two's-complement word (most negative value maps to itself,
  // which is the correct unsigned magnitude).
  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? ((~u) + WIDTH'(1)) : u;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return (~v) + W2'(1);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  b_abs_q, b_abs_d;
  logic [WIDTH-1:0]  a_raw_q, a_raw_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  // Local MSB-left copies of the bus operands.
  logic signed [WIDTH-1:0] a_in, b_in;
  logic        [WIDTH-1:0] wdata_in;
  assign a_in     = bus.opA;
  assign b_in     = bus.opB;
  assign wdata_in = bus.wdata;

  // Shift-add step: acc = {hi, lo}; lo holds the unconsumed multiplier bits.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_abs_q})
                             : {1'b0, acc_q[W2-1:WIDTH]};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient shift reg}.
  logic [WIDTH:0]   div_rs, div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  assign div_rs   = acc_q[W2-1:WIDTH-1];
  assign div_diff = div_rs - {1'b0, b_abs_q};
  assign div_qbit = ~div_diff[WIDTH];
  assign div_rem  = div_qbit ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
  assign div_next = {div_rem, acc_q[WIDTH-2:0], div_qbit};

  // op[0]=0 marks the signed variants.
  logic             is_signed_q;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign is_signed_q = ~op_q[0];
  assign prod_fix = (is_signed_q && (sa_q ^ sb_q)) ? neg_2w(acc_q) : acc_q;
  assign quo_fix  = (is_signed_q && (sa_q ^ sb_q)) ? neg_w(acc_q[WIDTH-1:0])
                                                   : acc_q[WIDTH-1:0];
  assign rem_fix  = (is_signed_q && sa_q) ? neg_w(acc_q[W2-1:WIDTH])
                                          : acc_q[W2-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      b_abs_q <= '0;
      a_raw_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_abs_q <= b_abs_d;
      a_raw_q <= a_raw_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_abs_d = b_abs_q;
    a_raw_d = a_raw_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // An mt write and a start in the same cycle are both honoured; the
        // operation result overwrites HI/LO later.
        if (bus.mt_hi) hi_d = wdata_in;
        if (bus.mt_lo) lo_d = wdata_in;
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = bus.op;
          sa_d    = ~bus.op[0] & a_in[WIDTH-1];
          sb_d    = ~bus.op[0] & b_in[WIDTH-1];
          acc_d   = {{WIDTH{1'b0}}, (bus.op[0] ? WIDTH'(a_in) : abs_w(a_in))};
          b_abs_d = bus.op[0] ? WIDTH'(b_in) : abs_w(b_in);
          a_raw_d = a_in;
          dz_d    = (b_in == '0);
        end
      end
      RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          // Divide by zero: raw dividend in HI, all ones in LO, no sign fix.
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed MULT/MULTU/DIV/DIVU
// results, divide-by-zero, start-while-busy, MTHI/MTLO and async reset.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns the edge index (counted from the start edge) after which done is
  // seen, or -1 if it never arrives within the budget.
  task automatic wait_done(input int already, output int lat, output int busy_cnt,
                           output logic busy_at_done, output logic dz);
    int k;
    lat = -1;
    busy_cnt = 0;
    busy_at_done = 1'bx;
    dz = 1'bx;
    k = already;
    while (k < 60) begin
      tick();
      k++;
      if (bus.done) begin
        lat = k;
        busy_at_done = bus.busy;
        dz = bus.div_by_zero;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  int   lat, bcnt, ndone;
  logic bdone, dz;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opA   = '0;
    bus.opB   = '0;
    bus.mt_hi = 1'b0;
    bus.mt_lo = 1'b0;
    bus.wdata = '0;
    tick();
    tick();
    chk("rst_hi",   bus.hi, 0);
    chk("rst_lo",   bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz",  bus.div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // MULTU max * max
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_e0", bus.busy, 1);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("multu_lat",       lat, 33);
    chk("multu_busy_cnt",  bcnt, 32);
    chk("multu_busy_done", bdone, 0);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_dbz", dz, 0);

    // MULT -3 * 7
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("mult_lat", lat, 33);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    // DIV -7 / 2
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("div_lat", lat, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_dbz", dz, 0);

    // DIVU 7 / 0
    launch(2'b11, 32'd7, 32'd0);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("dz_lat", lat, 33);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dz_hi", bus.hi, 32'd7);
    chk("dz_flag", dz, 1);
    tick();
    chk("dz_flag_drop", bus.div_by_zero, 0);
    chk("dz_done_drop", bus.done, 0);

    // DIV most-negative / -1
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0000_0000);
    chk("ovf_dbz", dz, 0);

    // MULTU 3*5 with a second start pulsed while busy
    launch(2'b01, 32'd3, 32'd5);
    for (int i = 1; i < 10; i++) tick();
    bus.op  = 2'b11;
    bus.opA = 32'd9;
    bus.opB = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(10, lat, bcnt, bdone, dz);
    chk("ign_lat", lat, 33);
    chk("ign_hi", bus.hi, 0);
    chk("ign_lo", bus.lo, 15);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("ign_no_second_done", ndone, 0);

    // MTHI while idle
    bus.wdata = 32'h1234_5678;
    bus.mt_hi = 1'b1;
    tick();
    bus.mt_hi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_lo_keep", bus.lo, 15);

    // MTLO while busy is dropped
    launch(2'b01, 32'd6, 32'd7);
    for (int i = 1; i < 5; i++) tick();
    bus.wdata = 32'hDEAD_BEEF;
    bus.mt_lo = 1'b1;
    tick();
    bus.mt_lo = 1'b0;
    tick();
    chk("mtlo_busy_lo", bus.lo, 15);
    wait_done(6, lat, bcnt, bdone, dz);
    chk("mtlo_busy_lat", lat, 33);
    chk("mtlo_busy_final_lo", bus.lo, 42);
    chk("mtlo_busy_final_hi", bus.hi, 0);

    // MTHI and start in the same idle cycle
    bus.wdata = 32'hAAAA_5555;
    bus.mt_hi = 1'b1;
    launch(2'b01, 32'd2, 32'd2);
    bus.mt_hi = 1'b0;
    chk("mt_start_hi", bus.hi, 32'hAAAA_5555);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("mt_start_res_hi", bus.hi, 0);
    chk("mt_start_res_lo", bus.lo, 4);

    // Asynchronous reset in the middle of a DIVU
    launch(2'b11, 32'd100, 32'd7);
    for (int i = 1; i <= 20; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hi",   bus.hi, 0);
    chk("arst_lo",   bus.lo, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle_busy", bus.busy, 0);
    launch(2'b01, 32'd2, 32'd3);
    wait_done(0, lat, bcnt, bdone, dz);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", bus.lo, 6);
    chk("post_rst_hi", bus.hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
